// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with a run-time programmable pattern, selectable
// overlapping/non-overlapping matching and a saturating match counter.
module pattern_detector #(
  parameter int unsigned           PATTERN_W   = 4,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [PATTERN_W-1:0]  RST_PATTERN = 4'b1111,
  parameter logic                  RST_OVERLAP = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_load_i,
  input  logic [PATTERN_W-1:0] cfg_pattern_i,
  input  logic                 cfg_overlap_i,
  input  logic                 data_valid_i,
  input  logic                 data_in_i,
  input  logic                 count_clear_i,
  output logic                 detected_o,
  output logic [CNT_W-1:0]     match_count_o
);

  localparam int unsigned        HistW   = PATTERN_W - 1;
  localparam int unsigned        FillW   = $clog2(PATTERN_W);
  localparam logic [FillW-1:0]   FillMax = FillW'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]   CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CntOne  = CNT_W'(1);

  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic                 overlap_q, overlap_d;
  logic [HistW-1:0]     hist_q, hist_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic                 detected_q, detected_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 accept;
  logic                 match;
  logic [PATTERN_W-1:0] window;

  // A bit arriving together with cfg_load is dropped.
  assign accept = data_valid_i & ~cfg_load_i;
  assign window = {hist_q, data_in_i};
  assign match  = accept && (fill_q == FillMax) && (window == pattern_q);

  always_comb begin
    pattern_d  = pattern_q;
    overlap_d  = overlap_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    detected_d = match;
    count_d    = count_q;

    if (cfg_load_i) begin
      pattern_d = cfg_pattern_i;
      overlap_d = cfg_overlap_i;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = window[HistW-1:0];
      if (match) begin
        // Non-overlapping mode needs a full window of fresh bits.
        fill_d = overlap_q ? fill_q : '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + 1'b1;
      end
    end

    if (count_clear_i) begin
      count_d = match ? CntOne : '0;
    end else if (match && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pattern_q  <= RST_PATTERN;
      overlap_q  <= RST_OVERLAP;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pattern_q  <= pattern_d;
      overlap_q  <= overlap_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= detected_d;
      count_q    <= count_d;
    end
  end

  assign detected_o    = detected_q;
  assign match_count_o = count_q;

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench for pattern_detector: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pattern_detector;

  localparam int PW     = 4;
  localparam int CW     = 3;
  localparam int CntMax = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_load = 1'b0;
  logic [PW-1:0] cfg_pattern = '0;
  logic          cfg_overlap = 1'b0;
  logic          data_valid = 1'b0;
  logic          data_in = 1'b0;
  logic          count_clear = 1'b0;
  logic          detected;
  logic [CW-1:0] match_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [PW-1:0] m_pat = '1;
  bit            m_ov = 1'b1;
  bit            m_hist[$];
  int            m_cnt = 0;
  bit            m_det = 1'b0;
  bit            m_live = 1'b0;

  always #5 clk = ~clk;

  pattern_detector #(
    .PATTERN_W   (PW),
    .CNT_W       (CW),
    .RST_PATTERN (4'b1111),
    .RST_OVERLAP (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_load_i    (cfg_load),
    .cfg_pattern_i (cfg_pattern),
    .cfg_overlap_i (cfg_overlap),
    .data_valid_i  (data_valid),
    .data_in_i     (data_in),
    .count_clear_i (count_clear),
    .detected_o    (detected),
    .match_count_o (match_count)
  );

  // Model: the queue holds bits accepted since the last flush; a match is the
  // newest PW bits equal to the pattern.
  always @(posedge clk) begin
    bit            hit;
    logic [PW-1:0] w;
    hit = 1'b0;
    w   = '0;
    if (rst) begin
      m_pat = 4'b1111;
      m_ov  = 1'b1;
      m_hist.delete();
      m_cnt  = 0;
      m_det  = 1'b0;
      m_live = 1'b1;
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_ov  = cfg_overlap;
        m_hist.delete();
      end else if (data_valid) begin
        if (m_hist.size() >= PW - 1) begin
          w[0] = data_in;
          for (int i = 1; i < PW; i++) w[i] = m_hist[m_hist.size() - i];
          hit = (w == m_pat);
        end
        m_hist.push_back(data_in);
        if (hit && !m_ov) m_hist.delete();
        if (m_hist.size() > 2 * PW) void'(m_hist.pop_front());
      end
      if (count_clear) m_cnt = hit ? 1 : 0;
      else if (hit && m_cnt < CntMax) m_cnt = m_cnt + 1;
      m_det = hit;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checks++;
      if (detected !== m_det || match_count !== m_cnt[CW-1:0]) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: dut det=%b cnt=%0d, model det=%0b cnt=%0d",
                 $time, detected, match_count, m_det, m_cnt);
      end
    end
  end

  // Literal expectation pinning both the DUT and the model; cnt < 0 skips count.
  task automatic expect_out(input string name, input bit det, input int cnt);
    checks++;
    if (detected !== det || m_det != det) begin
      errors++;
      $display("FAIL %s: detected dut=%b model=%0b want=%0b", name, detected, m_det, det);
    end
    if (cnt >= 0) begin
      checks++;
      if (match_count !== cnt[CW-1:0] || m_cnt != cnt) begin
        errors++;
        $display("FAIL %s: match_count dut=%0d model=%0d want=%0d",
                 name, match_count, m_cnt, cnt);
      end
    end
  endtask

  task automatic step(input bit v, input bit d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
    data_valid  = 1'b0;
    cfg_load    = 1'b0;
    count_clear = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic load(input logic [PW-1:0] p, input bit ov, input bit clr,
                      input bit v, input bit d);
    cfg_pattern = p;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    count_clear = clr;
    step(v, d);
  endtask

  initial begin
    bit seq[7];
    int cnt;
    int k;
    seq = '{1, 0, 1, 1, 0, 1, 1};

    // Reset defaults: 1111, overlapping
    rst = 1'b1;
    step(0, 0);
    expect_out("reset", 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 1);
      expect_out("default_ones", i >= 4, (i >= 4) ? i - 3 : 0);
    end

    // Non-overlapping 1111
    load(4'b1111, 0, 1, 0, 0);
    expect_out("load_nonoverlap", 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1);
      expect_out("nonoverlap_ones", (i == 4) || (i == 8), (i >= 8) ? 2 : (i >= 4) ? 1 : 0);
    end

    // 1011 overlapping, then the same stream with invalid gaps
    for (int pass = 0; pass < 2; pass++) begin
      load(4'b1011, 1, 1, 0, 0);
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
        if (pass == 1) begin
          k = $urandom_range(0, 2);
          for (int g = 0; g < k; g++) begin
            step(0, 1'($urandom_range(0, 1)));
            expect_out("gap_no_detect", 0, cnt);
          end
        end
        step(1, seq[i]);
        if (i == 3 || i == 6) cnt++;
        expect_out(pass ? "p1011_gaps" : "p1011", (i == 3) || (i == 6), cnt);
      end
    end

    // Bit arriving with cfg_load is dropped
    load(4'b1111, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1);
      expect_out("pre_load_ones", 0, 0);
    end
    load(4'b1111, 1, 0, 1, 1);
    expect_out("load_drops_bit", 0, 0);
    step(1, 1);
    expect_out("single_after_load", 0, 0);
    step(1, 1);
    expect_out("after_load_2", 0, 0);
    step(1, 1);
    expect_out("after_load_3", 0, 0);
    step(1, 1);
    expect_out("after_load_4", 1, 1);

    // Counter saturation and clear priority
    load(4'b1111, 1, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 1);
      cnt = (i >= 4) ? i - 3 : 0;
      if (cnt > CntMax) cnt = CntMax;
      expect_out("saturate", i >= 4, cnt);
    end
    count_clear = 1'b1;
    step(1, 1);
    expect_out("clear_with_match", 1, 1);
    count_clear = 1'b1;
    step(0, 0);
    expect_out("clear_alone", 0, 0);

    // rst in the cycle the completing bit arrives
    load(4'b0101, 1, 1, 0, 0);
    step(1, 0);
    step(1, 1);
    step(1, 0);
    expect_out("pre_rst", 0, 0);
    rst = 1'b1;
    step(1, 1);
    expect_out("rst_kills_match", 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 1);
      expect_out("post_rst_pattern", i == 4, (i == 4) ? 1 : 0);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 199);
      rst = (k == 0);
      if (k >= 1 && k <= 6) begin
        cfg_load = 1'b1;
        case ($urandom_range(0, 3))
          0:       cfg_pattern = 4'b1111;
          1:       cfg_pattern = 4'b1011;
          2:       cfg_pattern = 4'b0000;
          default: cfg_pattern = 4'($urandom_range(0, 15));
        endcase
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      count_clear = ($urandom_range(0, 24) == 0);
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
